// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, {ADDR,RW}, one data byte (write or read), STOP
// on open-drain SCL/SDA, with a START/DONE handshake toward the local controller.
//
// state      | meaning
// S_IDLE     | bus released, waiting for START_IN
// S_START    | q0-q1 bus idle, q2-q3 SDA low with SCL high
// S_ADDR     | 8 slots of {ADDR,RW}
// S_ADDR_ACK | SDA released, sample slave ACK
// S_WRITE    | 8 slots of write data
// S_WRITE_ACK| SDA released, sample slave ACK
// S_READ     | SDA released, assemble 8 sampled bits
// S_READ_ACK | master NACKs (SDA released), publish RDATA
// S_STOP     | SDA low, SCL rises in q2, SDA rises in q3
module i2c_master_byte #(
  parameter int CLK_DIV   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_IN,
  input  logic       START_IN,
  input  logic [6:0] ADDR_IN,
  input  logic       RW_IN,
  input  logic [7:0] WDATA_IN,
  output logic       BUSY_OUT,
  output logic       DONE_OUT,
  output logic       ACK_ERR_OUT,
  output logic [7:0] RDATA_OUT,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
    S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       q_q, q_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       addr_byte_q, wdata_q, rx_q, rdata_q;
  logic             rw_q, sda_smp_q;
  logic             scl_low_q, sda_low_q;
  logic             busy_q, done_q, ack_err_q;
  logic             hold, tick, slot_end;
  logic [1:0]       drive_d;

  function automatic logic [2:0] bit_idx(input logic [2:0] b);
    return LSB_FIRST ? b : (3'd7 - b);
  endfunction

  // Returns {scl_low, sda_low} for a given slot position.
  function automatic logic [1:0] bus_drive(input state_t s, input logic [1:0] q,
                                           input logic [2:0] b, input logic [7:0] ab,
                                           input logic [7:0] wd);
    logic scl_l;
    scl_l = (q < 2'd2);
    case (s)
      S_START:     return {1'b0, q >= 2'd2};
      S_ADDR:      return {scl_l, ~ab[bit_idx(b)]};
      S_WRITE:     return {scl_l, ~wd[bit_idx(b)]};
      S_ADDR_ACK,
      S_WRITE_ACK,
      S_READ,
      S_READ_ACK:  return {scl_l, 1'b0};
      S_STOP:      return {scl_l, q != 2'd3};
      default:     return 2'b00;
    endcase
  endfunction

  // Stretching: a released SCL that still reads low freezes the divider in q2.
  always_comb begin
    hold     = (state_q != S_IDLE) && (q_q == 2'd2) && !scl_low_q && (SCL == 1'b0);
    tick     = (state_q != S_IDLE) && !hold && (div_q == DIV_LAST);
    slot_end = tick && (q_q == 2'd3);
    state_d  = state_q;
    q_d      = q_q;
    bit_d    = bit_q;
    if (state_q == S_IDLE) begin
      if (START_IN) begin
        state_d = S_START;
        q_d     = 2'd0;
        bit_d   = 3'd0;
      end
    end else if (tick) begin
      q_d = q_q + 2'd1;
      if (slot_end) begin
        case (state_q)
          S_START:     state_d = S_ADDR;
          S_ADDR: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ADDR_ACK;
          end
          S_ADDR_ACK:  state_d = sda_smp_q ? S_STOP : (rw_q ? S_READ : S_WRITE);
          S_WRITE: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_WRITE_ACK;
          end
          S_READ: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_READ_ACK;
          end
          S_WRITE_ACK,
          S_READ_ACK:  state_d = S_STOP;
          S_STOP:      state_d = S_IDLE;
          default:     state_d = S_IDLE;
        endcase
      end
    end
    drive_d = bus_drive(state_d, q_d, bit_d, addr_byte_q, wdata_q);
  end

  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      q_q         <= 2'd0;
      bit_q       <= 3'd0;
      addr_byte_q <= 8'h00;
      wdata_q     <= 8'h00;
      rx_q        <= 8'h00;
      rdata_q     <= 8'h00;
      rw_q        <= 1'b0;
      sda_smp_q   <= 1'b1;
      scl_low_q   <= 1'b0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      scl_low_q <= drive_d[1];
      sda_low_q <= drive_d[0];
      done_q    <= 1'b0;
      if (state_q == S_IDLE) begin
        div_q <= '0;
        if (START_IN) begin
          addr_byte_q <= {ADDR_IN, RW_IN};
          rw_q        <= RW_IN;
          wdata_q     <= WDATA_IN;
          busy_q      <= 1'b1;
          ack_err_q   <= 1'b0;
        end
      end else begin
        if (!hold) div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (tick && (q_q == 2'd2)) begin
          sda_smp_q <= SDA;
          if (state_q == S_READ) rx_q[bit_idx(bit_q)] <= SDA;
        end
        if (slot_end) begin
          case (state_q)
            S_ADDR_ACK,
            S_WRITE_ACK: if (sda_smp_q) ack_err_q <= 1'b1;
            S_READ_ACK:  rdata_q <= rx_q;
            S_STOP: begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign SCL         = scl_low_q ? 1'b0 : 1'bz;
  assign SDA         = sda_low_q ? 1'b0 : 1'bz;
  assign BUSY_OUT    = busy_q;
  assign DONE_OUT    = done_q;
  assign ACK_ERR_OUT = ack_err_q;
  assign RDATA_OUT   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: open-drain bus with pull-ups, a behavioural slave
// and a bus monitor whose sampled bits are checked against a queue of expected bits.
module tb_i2c_master_byte;
  localparam int CLK_DIV   = 4;
  localparam bit LSB_FIRST = 1'b1;
  localparam int FULL      = 80 * CLK_DIV;
  localparam int NACK_LAT  = 44 * CLK_DIV;
  localparam int STRETCH   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  wire        scl_w, sda_w;
  logic       scl_pull = 1'b0;
  logic       sda_pull = 1'b0;

  pullup (scl_w);
  pullup (sda_w);
  assign scl_w = scl_pull ? 1'b0 : 1'bz;
  assign sda_w = sda_pull ? 1'b0 : 1'bz;

  i2c_master_byte #(.CLK_DIV(CLK_DIV), .LSB_FIRST(LSB_FIRST)) dut (
    .CLK(clk), .RESET_IN(rst), .START_IN(start), .ADDR_IN(addr), .RW_IN(rw),
    .WDATA_IN(wdata), .BUSY_OUT(busy), .DONE_OUT(done), .ACK_ERR_OUT(ack_err),
    .RDATA_OUT(rdata), .SCL(scl_w), .SDA(sda_w)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic obs_q[$];
  logic exp_q[$];
  int   start_cnt = 0;
  int   stop_cnt = 0;
  logic       slv_ack_addr = 1'b1;
  logic       slv_ack_data = 1'b1;
  logic       slv_read = 1'b0;
  logic       slv_stretch = 1'b0;
  logic [7:0] slv_rbyte = 8'h00;

  // Bus monitor and slave, both working on values sampled at the falling CLK edge.
  initial begin : bus_model
    logic pscl, psda;
    int   slot, hold;
    pscl = 1'b1; psda = 1'b1; slot = -1; hold = 0;
    forever begin
      @(negedge clk);
      if (pscl === 1'b1 && scl_w === 1'b1 && psda === 1'b1 && sda_w === 1'b0) begin
        start_cnt++;
        slot = -1;
      end
      if (pscl === 1'b1 && scl_w === 1'b1 && psda === 1'b0 && sda_w === 1'b1) stop_cnt++;
      if (pscl === 1'b0 && scl_w === 1'b1) obs_q.push_back(sda_w);
      if (pscl === 1'b1 && scl_w === 1'b0) begin
        slot++;
        sda_pull = 1'b0;
        if (slot == 8) begin
          sda_pull = slv_ack_addr;
          if (slv_stretch) begin
            scl_pull = 1'b1;
            hold = 2 * CLK_DIV + STRETCH;
          end
        end else if (slot >= 9 && slot <= 16 && slv_read) begin
          sda_pull = ~slv_rbyte[LSB_FIRST ? (slot - 9) : (16 - slot)];
        end else if (slot == 17 && !slv_read) begin
          sda_pull = slv_ack_data;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) scl_pull = 1'b0;
      end
      pscl = scl_w;
      psda = sda_w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int obs, input int exp);
    checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
    end
  endtask

  // Bits the monitor should see on each SCL rise, ending with the STOP-phase rise (SDA low).
  task automatic push_expected(input logic [6:0] a, input logic r, input logic [7:0] wd,
                               input logic aa, input logic ad, input logic [7:0] rb);
    logic [7:0] b;
    b = {a, r};
    for (int i = 0; i < 8; i++) exp_q.push_back(b[LSB_FIRST ? i : 7 - i]);
    exp_q.push_back(~aa);
    if (aa) begin
      b = r ? rb : wd;
      for (int i = 0; i < 8; i++) exp_q.push_back(b[LSB_FIRST ? i : 7 - i]);
      exp_q.push_back(r ? 1'b1 : ~ad);
    end
    exp_q.push_back(1'b0);
  endtask

  task automatic run_xfer(input string tag, input logic [6:0] a, input logic r,
                          input logic [7:0] wd, input logic aa, input logic ad,
                          input logic [7:0] rb, input logic strt, input logic mid_start,
                          input int exp_lat, input logic exp_err, output int lat);
    int   cyc, n;
    logic busy_ok;
    obs_q.delete(); exp_q.delete();
    start_cnt = 0; stop_cnt = 0;
    slv_ack_addr = aa; slv_ack_data = ad; slv_read = r; slv_rbyte = rb; slv_stretch = strt;
    push_expected(a, r, wd, aa, ad, rb);
    @(negedge clk);
    addr = a; rw = r; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; addr = ~a; wdata = ~wd; rw = ~r;
    cyc = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 2000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (mid_start && cyc == 100) begin start = 1'b1; addr = 7'h11; end
      if (mid_start && cyc == 101) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    check_lat({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_held"}, busy_ok, 1'b1);
    check({tag, "_ack_err"}, ack_err, exp_err);
    check({tag, "_start_cond"}, start_cnt, 1);
    check({tag, "_stop_cond"}, stop_cnt, 1);
    check({tag, "_nbits"}, obs_q.size(), exp_q.size());
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check($sformatf("%s_bit%0d", tag, n), obs_q.pop_front(), exp_q.pop_front());
      n++;
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin : main
    int lat_w, lat, done_seen;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, ack_err, rdata}, 11'h000);
    check("rst_bus", {scl_w, sda_w}, 2'b11);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_xfer("wr_a5", 7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, FULL, 1'b0, lat_w);
    run_xfer("rd_3c", 7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, FULL, 1'b0, lat);
    check("rd_rdata", rdata, 8'h3C);
    run_xfer("addr_nack", 7'h2A, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, NACK_LAT, 1'b1, lat);
    check("rdata_held", rdata, 8'h3C);
    run_xfer("data_nack", 7'h55, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, FULL, 1'b1, lat);
    run_xfer("mid_start", 7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, FULL, 1'b0, lat);
    run_xfer("stretch", 7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, FULL + STRETCH, 1'b0, lat);
    check("stretch_delta", lat - lat_w, STRETCH);

    // Reset while the first write-data bit (a 0) is on the bus with SCL low.
    slv_ack_addr = 1'b1; slv_ack_data = 1'b1; slv_read = 1'b0; slv_stretch = 1'b0;
    @(negedge clk);
    addr = 7'h2A; rw = 1'b0; wdata = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (165) @(negedge clk);
    check("rst_mid_pre_bus", {scl_w, sda_w}, 2'b00);
    rst = 1'b1;
    #1;
    check("rst_mid_bus", {scl_w, sda_w}, 2'b11);
    check("rst_mid_busy", busy, 1'b0);
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 0);
    check("rst_mid_rdata", rdata, 8'h00);
    run_xfer("wr_5a", 7'h2A, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, FULL, 1'b0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
